mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, the data width in bits.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive data grants allowed while a fetch is waiting; legal range 1..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_req, input, 1 bit: instruction-fetch read request.
REQ-007 SHALL have port i_addr, input, ADDR_W bits: fetch address.
REQ-008 SHALL have port i_gnt, output, 1 bit: the fetch request is accepted this cycle.
REQ-009 SHALL have ports i_rvalid (output, 1 bit) and i_rdata (output, DATA_W bits): fetch response.
REQ-010 SHALL have ports d_req (1 bit), d_we (1 bit), d_addr (ADDR_W bits) and d_wdata (DATA_W bits), all inputs: data-port request.
REQ-011 SHALL have port d_gnt, output, 1 bit: the data request is accepted this cycle.
REQ-012 SHALL have ports d_rvalid (output, 1 bit) and d_rdata (output, DATA_W bits): data response; for writes, d_rvalid is the write acknowledge.
REQ-013 SHALL have ports mem_addr (ADDR_W bits), mem_wdata (DATA_W bits) and mem_we (1 bit), all outputs: the shared memory port.
REQ-014 SHALL have port mem_rdata, input, DATA_W bits: memory read data, valid 1 cycle after the address is presented.
REQ-015 SHALL have ports i_count and d_count, outputs, 32 bits each: grant counters.

Function
REQ-016 Grants SHALL be combinational from the current-cycle requests and the starvation count; a transfer occurs when req and gnt are both high.
REQ-017 At most one of i_gnt and d_gnt SHALL be high in any cycle.
REQ-018 Arbitration SHALL be:
- d_req high and not (starve_cnt == STARVE_LIMIT with i_req high): d_gnt.
- Otherwise, if i_req is high: i_gnt.
- Otherwise: no grant.
REQ-019 The memory port SHALL be driven as:
- mem_addr = d_addr when d_gnt is high, otherwise i_addr.
- mem_wdata = d_wdata.
- mem_we = d_gnt & d_we.
REQ-020 A response-tracking FSM SHALL have states IDLE, RESP_I and RESP_D; the next state is RESP_D on d_gnt, RESP_I on i_gnt, and IDLE when there is no grant; transitions occur in every state, giving back-to-back throughput of 1 transfer per cycle.
REQ-021 In RESP_I, i_rvalid SHALL be 1 and i_rdata = mem_rdata; in any other state, i_rvalid = 0 and i_rdata = 0.
REQ-022 In RESP_D, d_rvalid SHALL be 1; d_rdata = mem_rdata for a read and 0 for a write (the write flag is registered at grant); in any other state, d_rdata = 0.
REQ-023 The response latency SHALL be exactly 1 cycle after the grant cycle, for both ports.
REQ-024 starve_cnt (4 bits) SHALL update as follows:
- Increments when d_gnt is high and i_req is high.
- Clears when i_gnt is high or i_req is low.
- Saturates at STARVE_LIMIT.
REQ-025 When both requesters are high on every cycle, the grant pattern SHALL be STARVE_LIMIT data grants, then 1 fetch grant, repeating.
REQ-026 A requester SHALL hold req, addr and data stable until granted; the arbiter SHALL NOT latch ungranted requests.
REQ-027 i_count and d_count SHALL increment by 1 on each i_gnt and d_gnt respectively, wrapping from 0xFFFFFFFF to 0.
REQ-028 A write and a read to the same address in consecutive grants SHALL be ordered by grant order; the arbiter provides no forwarding.

Reset
REQ-029 While rst_n = 0, regardless of clk, the block SHALL hold: FSM = IDLE, starve_cnt = 0, i_count = 0, d_count = 0, i_rvalid = 0, d_rvalid = 0, i_rdata = 0, d_rdata = 0.
REQ-030 A reset asserted during RESP_I or RESP_D SHALL drop the pending response; no rvalid is issued after reset is released.
REQ-031 While rst_n = 0, the grants SHALL be forced to 0 and mem_we forced to 0.

Verification
REQ-032 Fetch only: i_req = 1 with i_addr = 0x0, 0x4, 0x8 on consecutive cycles -> i_gnt high on each cycle; i_rvalid on the next 3 cycles with the memory words at those addresses; i_count = 3.
REQ-033 Data write then read: d_we = 1, addr 0x10, wdata 0xDEADBEEF, followed by a read of 0x10 -> mem_we high for 1 cycle; d_rvalid with d_rdata = 0 for the write; the read returns 0xDEADBEEF.
REQ-034 Contention, STARVE_LIMIT = 4: i_req and d_req held high for 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I.
REQ-035 Counter clear: i_req drops for 1 cycle during a data burst -> starve_cnt = 0; the next fetch waits a further 4 data grants.
REQ-036 Reset mid-read: rst_n is pulsed low asynchronously in the cycle after d_gnt -> d_rvalid is never asserted; all counters are 0; the first grant after release is served normally.
REQ-037 Count wrap: d_count is preloaded via force to 0xFFFFFFFF, then 1 data grant -> d_count = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port and a
// data port. Grants are combinational; responses come back one cycle later.
// Data has priority, but a waiting fetch is forced through after STARVE_LIMIT
// consecutive data grants.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // shared memory port
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    // grant counters
    output logic [31:0]       i_count,
    output logic [31:0]       d_count
);

    typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic [3:0] starve_cnt;
    logic       d_we_q;
    logic       starved;

    // Fetch has waited out its allowance: it wins this cycle.
    assign starved = (starve_cnt == LIMIT) && i_req;

    // Grants are gated by rst_n so nothing reaches memory while in reset.
    assign d_gnt = rst_n && d_req && !starved;
    assign i_gnt = rst_n && i_req && !d_gnt;

    assign mem_addr  = d_gnt ? d_addr : i_addr;
    assign mem_wdata = d_wdata;
    assign mem_we    = d_gnt && d_we;

    // Next response state follows whichever port was granted this cycle.
    always_comb begin
        state_d = IDLE;
        if (d_gnt)      state_d = RESP_D;
        else if (i_gnt) state_d = RESP_I;
    end

    // Response state register; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Remember whether the granted data access was a write, for its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     d_we_q <= 1'b0;
        else if (d_gnt) d_we_q <= d_we;
    end

    // Count data grants taken while a fetch waits; clear once fetch is served or gone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           starve_cnt <= '0;
        else if (!i_req || i_gnt)             starve_cnt <= '0;
        else if (d_gnt && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end

    // Free-running grant counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_count <= '0;
            d_count <= '0;
        end else begin
            if (i_gnt) i_count <= i_count + 32'd1;
            if (d_gnt) d_count <= d_count + 32'd1;
        end
    end

    // Route memory read data to the port whose response is due this cycle.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        case (state_q)
            RESP_I: begin
                i_rvalid = 1'b1;
                i_rdata  = mem_rdata;
            end
            RESP_D: begin
                d_rvalid = 1'b1;
                d_rdata  = d_we_q ? '0 : mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [31:0] i_count, d_count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .i_count(i_count), .d_count(d_count)
    );

    // Memory model: write takes effect at the edge, read data one cycle later.
    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 32'hA000_0000 + 32'(k);
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : mem[mem_addr[9:2]];
    end

    // Advance to just after the next rising edge; inputs are set there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        i_req = 1; d_req = 1; d_we = 1;
        #3;
        checks++; if (i_gnt !== 1'b0) begin errors++; $display("FAIL reset_i_gnt got %0b want 0", i_gnt); end
        checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL reset_d_gnt got %0b want 0", d_gnt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
        step(); step();
        checks++; if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %0b/%0b want 0/0", i_rvalid, d_rvalid); end
        checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", i_rdata, d_rdata); end
        checks++; if (i_count !== 32'h0 || d_count !== 32'h0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", i_count, d_count); end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    task automatic test_fetch();
        logic [31:0] base;
        base = i_count;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin i_req = 1; i_addr = 32'(4 * k); end
            else       begin i_req = 0; i_addr = '0; end
            #1;
            if (k < 3) begin
                checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt[%0d] got %0b want 1", k, i_gnt); end
            end
            if (k > 0) begin
                checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0000 + 32'(k - 1))
                    begin errors++; $display("FAIL fetch_rdata[%0d] got %0b/%h want 1/%h", k, i_rvalid, i_rdata, 32'hA000_0000 + 32'(k - 1)); end
            end
            step();
        end
        #1;
        checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_rvalid_end got %0b want 0", i_rvalid); end
        checks++; if (i_count !== base + 32'd3) begin errors++; $display("FAIL fetch_count got %0d want %0d", i_count, base + 32'd3); end
        step();
    endtask

    task automatic test_write_read();
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_gnt_we got %0b/%0b want 1/1", d_gnt, mem_we); end
        step();
        d_we = 0; d_wdata = '0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rd_mem_we got %0b want 0", mem_we); end
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL wr_ack got %0b/%h want 1/0", d_rvalid, d_rdata); end
        step();
        idle_inputs();
        #1;
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %0b/%h want 1/deadbeef", d_rvalid, d_rdata); end
        step();
    endtask

    task automatic test_contention();
        logic [9:0] pat;
        pat = 10'b1111011110;   // 1 = data grant, 0 = fetch grant
        i_req = 1; i_addr = 32'h40; d_req = 1; d_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++; if (d_gnt !== pat[9-k] || i_gnt !== !pat[9-k])
                begin errors++; $display("FAIL contention[%0d] got d=%0b i=%0b want d=%0b", k, d_gnt, i_gnt, pat[9-k]); end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_starve_clear();
        logic [7:0] ireq_pat, dexp;
        ireq_pat = 8'b11011111;  // fetch request drops on the third cycle
        dexp     = 8'b11111110;  // only the last cycle grants the fetch
        d_req = 1; d_addr = 32'h80; i_addr = 32'h40;
        for (int k = 0; k < 8; k++) begin
            i_req = ireq_pat[7-k];
            #1;
            checks++; if (d_gnt !== dexp[7-k] || i_gnt !== (ireq_pat[7-k] && !dexp[7-k]))
                begin errors++; $display("FAIL starve_clear[%0d] got d=%0b i=%0b want d=%0b", k, d_gnt, i_gnt, dexp[7-k]); end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h20;
        step();
        idle_inputs();
        #1;
        rst_n = 0;   // asynchronous, mid-cycle while the read response is due
        #1;
        checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %0b want 0", d_rvalid); end
        checks++; if (i_count !== 32'h0 || d_count !== 32'h0) begin errors++; $display("FAIL midrst_counts got %0d/%0d want 0/0", i_count, d_count); end
        @(negedge clk);
        rst_n = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL midrst_post_rvalid[%0d] got %0b want 0", k, d_rvalid); end
        end
        i_req = 1; i_addr = 32'h8;
        #1;
        checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL midrst_first_gnt got %0b want 1", i_gnt); end
        step();
        idle_inputs();
        #1;
        checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'hA000_0002) begin errors++; $display("FAIL midrst_first_rdata got %0b/%h want 1/a0000002", i_rvalid, i_rdata); end
        step();
    endtask

    task automatic test_wrap();
        force dut.d_count = 32'hFFFF_FFFF;
        #1;
        release dut.d_count;
        #1;
        checks++; if (d_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h want ffffffff", d_count); end
        d_req = 1; d_addr = 32'h4;
        step();
        idle_inputs();
        #1;
        checks++; if (d_count !== 32'h0) begin errors++; $display("FAIL wrap_count got %h want 0", d_count); end
        step();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write_read();
        test_contention();
        test_starve_clear();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
